// File: rtl/temp_dt_frontend.sv
// temp_dt_frontend
//   Front-end ahead of the fuzzy evaluation core. It accepts signed temperature
//   samples T and emits (T, dT) pairs over a valid/ready handshake. dT is either
//   passed through from in_dt_i or derived as the per-sample slope over the last
//   N = 2^AVG_LOG2 samples. The history is updated in both modes, so switching
//   modes does not produce a dT spike.
// Ports
//   clk, rst_n          clock, async active-low reset
//   init_i              reseed request; the next accepted sample seeds the history
//   dt_mode_i           1 = internal slope, 0 = pass in_dt_i through
//   in_valid_i/in_ready_o, in_t_i, in_dt_i     input sample handshake
//   out_valid_o/out_ready_i, out_t_o, out_dt_o output pair handshake
//   primed_o            history holds valid samples (RUN state)
module temp_dt_frontend #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_i,
  input  logic       dt_mode_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_t_i,
  input  logic [7:0] in_dt_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_t_o,
  output logic [7:0] out_dt_o,
  output logic       primed_o
);
  localparam int N    = 1 << AVG_LOG2;
  // AVG_LOG2 = 0 still needs a 1-bit pointer; it is held at 0 in that case.
  localparam int WP_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

  typedef enum logic {EMPTY = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q;
  logic [N-1:0][7:0] hist_q;
  logic [WP_W-1:0]   wp_q, wp_d;
  logic              out_valid_q;
  logic [7:0]        out_t_q, out_dt_q;

  logic              accept, seed;
  logic [7:0]        old_t, dt_run, dt_int;
  logic signed [8:0] diff, sh;

  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  // init wins over the RUN path: a coincident sample becomes the seed.
  assign seed        = (state_q == EMPTY) || init_i;
  assign out_valid_o = out_valid_q;
  assign out_t_o     = out_t_q;
  assign out_dt_o    = out_dt_q;
  assign primed_o    = (state_q == RUN);

  always_comb begin
    old_t  = hist_q[wp_q];
    // 9-bit signed difference cannot overflow for 8-bit signed operands.
    diff   = $signed({in_t_i[7], in_t_i}) - $signed({old_t[7], old_t});
    sh     = diff >>> AVG_LOG2;
    // Only reachable for AVG_LOG2 = 0; wider windows always fit in 8 bits.
    if (sh > 9'sd127)       dt_run = 8'h7F;
    else if (sh < -9'sd128) dt_run = 8'h80;
    else                    dt_run = sh[7:0];
    dt_int = seed ? 8'h00 : dt_run;
    wp_d   = (AVG_LOG2 == 0) ? '0 : wp_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      hist_q      <= '0;
      wp_q        <= '0;
      out_valid_q <= 1'b0;
      out_t_q     <= '0;
      out_dt_q    <= '0;
    end else begin
      if (accept) begin
        if (seed) begin
          // Fill every entry so the first slopes after seeding are flat.
          for (int i = 0; i < N; i++) hist_q[i] <= in_t_i;
        end else begin
          hist_q[wp_q] <= in_t_i;
          wp_q         <= wp_d;
        end
        out_valid_q <= 1'b1;
        out_t_q     <= in_t_i;
        out_dt_q    <= dt_mode_i ? dt_int : in_dt_i;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      if (init_i)      state_q <= EMPTY;
      else if (accept) state_q <= RUN;
    end
  end
endmodule

// File: tb/tb_temp_dt_frontend.sv
// Bench for temp_dt_frontend: two instances (AVG_LOG2 = 2 and 0), a directed
// vector table, hand sequences for backpressure/saturation/reset, and a
// randomized run against a queue-based history model.
module tb_temp_dt_frontend;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: AVG_LOG2 = 2 (N = 4), index 1: AVG_LOG2 = 0 (N = 1)
  logic       ini[2], dtm[2], iv[2], ir[2], ov[2], ordy[2], pr[2];
  logic [7:0] it[2], idt[2], ot[2], odt[2];

  temp_dt_frontend #(.AVG_LOG2(2)) u_n4 (
    .clk(clk), .rst_n(rst_n), .init_i(ini[0]), .dt_mode_i(dtm[0]),
    .in_valid_i(iv[0]), .in_ready_o(ir[0]), .in_t_i(it[0]), .in_dt_i(idt[0]),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .out_t_o(ot[0]),
    .out_dt_o(odt[0]), .primed_o(pr[0]));

  temp_dt_frontend #(.AVG_LOG2(0)) u_n1 (
    .clk(clk), .rst_n(rst_n), .init_i(ini[1]), .dt_mode_i(dtm[1]),
    .in_valid_i(iv[1]), .in_ready_o(ir[1]), .in_t_i(it[1]), .in_dt_i(idt[1]),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .out_t_o(ot[1]),
    .out_dt_o(odt[1]), .primed_o(pr[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input bit i_init, input bit i_dtm,
                       input bit i_v, input bit i_r, input int i_t, input int i_dt);
    ini[k] = i_init; dtm[k] = i_dtm; iv[k] = i_v; ordy[k] = i_r;
    it[k] = i_t[7:0]; idt[k] = i_dt[7:0];
  endtask

  task automatic idle(input int k);
    drive(k, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string tag, input int k, input bit ev,
                         input int et, input int edt, input bit ep);
    chk({tag, ".valid"},  int'(ov[k]), int'(ev));
    chk({tag, ".t"},      int'($signed(ot[k])), et);
    chk({tag, ".dt"},     int'($signed(odt[k])), edt);
    chk({tag, ".primed"}, int'(pr[k]), int'(ep));
  endtask

  // ---------------- reference model ----------------
  // The history is the list of the last N accepted samples, oldest first.
  int  m_hist[2][$];
  bit  m_pr[2], m_ov[2];
  int  m_t[2], m_dt[2];

  function automatic int nof(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int floor_div(input int a, input int n);
    return (a >= 0) ? a / n : (a - (n - 1)) / n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hist[k].delete();
      for (int j = 0; j < nof(k); j++) m_hist[k].push_back(0);
      m_pr[k] = 0; m_ov[k] = 0; m_t[k] = 0; m_dt[k] = 0;
    end
  endtask

  // Called with the inputs that were present at the clock edge.
  task automatic model_step(input int k);
    int t, d, diff;
    bit acc;
    t   = int'($signed(it[k]));
    acc = iv[k] && (!m_ov[k] || ordy[k]);
    if (acc) begin
      if (!m_pr[k] || ini[k]) begin
        m_hist[k].delete();
        for (int j = 0; j < nof(k); j++) m_hist[k].push_back(t);
        d = 0;
      end else begin
        diff = t - m_hist[k][0];
        d = floor_div(diff, nof(k));
        if (d > 127) d = 127;
        if (d < -128) d = -128;
        void'(m_hist[k].pop_front());
        m_hist[k].push_back(t);
      end
      m_ov[k] = 1;
      m_t[k]  = t;
      m_dt[k] = dtm[k] ? d : int'($signed(idt[k]));
    end else if (ordy[k]) begin
      m_ov[k] = 0;
    end
    if (ini[k]) m_pr[k] = 0;
    else if (acc) m_pr[k] = 1;
  endtask

  // ---------------- directed table (N = 4 instance) ----------------
  typedef struct {
    bit ini, dtm, v, r;
    int t, dt;
    bit ev;
    int et, edt;
    bit ep;
  } vec_t;
  vec_t tbl[$];

  initial begin
    // pass-through
    tbl.push_back('{0,0,1,1, 100,-100, 1,100,-100,1});
    tbl.push_back('{1,1,0,1,   0,   0, 0,100,-100,0});
    // ramp with N = 4, including pointer wrap on 20 and 24
    tbl.push_back('{0,1,1,1,   0, 0, 1,  0, 0, 1});
    tbl.push_back('{0,1,1,1,   4, 0, 1,  4, 1, 1});
    tbl.push_back('{0,1,1,1,   8, 0, 1,  8, 2, 1});
    tbl.push_back('{0,1,1,1,  12, 0, 1, 12, 3, 1});
    tbl.push_back('{0,1,1,1,  16, 0, 1, 16, 4, 1});
    tbl.push_back('{0,1,1,1,  20, 0, 1, 20, 4, 1});
    tbl.push_back('{0,1,1,1,  24, 0, 1, 24, 4, 1});
    // floor rounding
    tbl.push_back('{1,1,0,1,   0, 0, 0, 24, 4, 0});
    tbl.push_back('{0,1,1,1,   0, 0, 1,  0, 0, 1});
    tbl.push_back('{0,1,1,1,  -1, 0, 1, -1,-1, 1});
    // history of 120 built in pass-through mode, then switch mode: no spike
    for (int i = 0; i < 4; i++) tbl.push_back('{0,0,1,1, 120, 5, 1,120, 5, 1});
    tbl.push_back('{0,1,1,1, 120, 0, 1,120, 0, 1});
    // init over a 120 history, then five zeros stay flat
    tbl.push_back('{1,1,0,1,   0, 0, 0,120, 0, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{0,1,1,1, 0, 0, 1, 0, 0, 1});
  end

  // ---------------- main sequence ----------------
  initial begin
    idle(0); idle(1);
    model_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_out($sformatf("reset%0d", k), k, 0, 0, 0, 0);
      chk($sformatf("reset%0d.in_ready", k), int'(ir[k]), 1);
    end

    // Five zeros right after an init on a fresh instance.
    drive(0, 1, 1, 0, 1, 0, 0); tick();
    // (covered again by the table; this just exercises init with nothing pending)
    chk_out("init_idle", 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(0, tbl[i].ini, tbl[i].dtm, tbl[i].v, tbl[i].r, tbl[i].t, tbl[i].dt);
      tick();
      chk_out($sformatf("tbl[%0d]", i), 0, tbl[i].ev, tbl[i].et, tbl[i].edt, tbl[i].ep);
    end

    // Backpressure: pair A pending, B offered while out_ready is low.
    drive(0, 0, 0, 1, 1, 10, 1); tick();
    chk_out("bp.A", 0, 1, 10, 1, 1);
    drive(0, 0, 1, 1, 0, 20, 2); #1;
    chk("bp.in_ready_low", int'(ir[0]), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("bp.hold%0d", c), 0, 1, 10, 1, 1);
      chk($sformatf("bp.hold%0d.in_ready", c), int'(ir[0]), 0);
    end
    drive(0, 0, 0, 1, 1, 20, 2); #1;
    chk("bp.in_ready_high", int'(ir[0]), 1);
    tick();
    chk_out("bp.B", 0, 1, 20, 2, 1);
    idle(0); tick();
    chk_out("bp.drain", 0, 0, 20, 2, 1);

    // Saturation on the N = 1 instance.
    drive(1, 0, 1, 1, 1, -128, 0); tick(); chk_out("sat.seed_lo", 1, 1, -128, 0, 1);
    drive(1, 0, 1, 1, 1,  127, 0); tick(); chk_out("sat.pos",     1, 1,  127, 127, 1);
    drive(1, 1, 1, 0, 1,    0, 0); tick(); chk_out("sat.init",    1, 0,  127, 127, 0);
    drive(1, 0, 1, 1, 1,  127, 0); tick(); chk_out("sat.seed_hi", 1, 1,  127, 0, 1);
    drive(1, 0, 1, 1, 1, -128, 0); tick(); chk_out("sat.neg",     1, 1, -128, -128, 1);
    // init coincident with an accept: that sample is the seed.
    drive(1, 1, 1, 1, 1,   50, 0); tick();
    chk("sat.init_acc.valid", int'(ov[1]), 1);
    chk("sat.init_acc.t",  int'($signed(ot[1])), 50);
    chk("sat.init_acc.dt", int'($signed(odt[1])), 0);
    idle(1); tick();

    // Reset while a pair is pending drops it asynchronously.
    drive(0, 0, 0, 1, 0, 33, 7); tick();
    chk("rst_mid.pending", int'(ov[0]), 1);
    idle(0);
    rst_n = 1'b0; #1;
    chk("rst_mid.valid", int'(ov[0]), 0);
    chk("rst_mid.primed", int'(pr[0]), 0);
    chk("rst_mid.t", int'(ot[0]), 0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();

    // Randomized run against the model on both instances.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 2; k++) begin
        bit v, r, in_i;
        v    = ($urandom % 4) != 0;
        r    = ($urandom % 4) != 0;
        in_i = !v && (($urandom % 12) == 0);
        drive(k, in_i, 1'($urandom % 2), v, r, int'($urandom % 256) - 128,
              int'($urandom % 256) - 128);
      end
      #1;
      for (int k = 0; k < 2; k++)
        chk($sformatf("rnd%0d[%0d].in_ready", k, c), int'(ir[k]),
            int'(!m_ov[k] || ordy[k]));
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd%0d[%0d].valid", k, c), int'(ov[k]), int'(m_ov[k]));
        chk($sformatf("rnd%0d[%0d].primed", k, c), int'(pr[k]), int'(m_pr[k]));
        if (m_ov[k]) begin
          chk($sformatf("rnd%0d[%0d].t", k, c), int'($signed(ot[k])), m_t[k]);
          chk($sformatf("rnd%0d[%0d].dt", k, c), int'($signed(odt[k])), m_dt[k]);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/temp_dt_frontend.md
# temp_dt_frontend

Sample front-end directly upstream of the fuzzy evaluation core. Accepts a stream of signed temperature samples T and emits (T, dT) pairs to the core over a valid/ready handshake. With DT_MODE=1, dT is derived internally as the per-sample slope over a window of 2^AVG_LOG2 samples. With DT_MODE=0, a caller-supplied dT is passed through; the internal history is still maintained so switching modes causes no spike. An INIT pulse reseeds the history so the first post-INIT output has dT=0.

## Interface
- AVG_LOG2, default 2: log2 of history depth N (N = 2^AVG_LOG2); legal range 0..4.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init  in  1  single-cycle pulse; clears `primed` so the next accepted sample reseeds the history.
- dt_mode  in  1  0 = pass in_dt through; 1 = derive dT internally. Sampled on the accept cycle.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample; defined as !out_valid || out_ready (combinational).
- in_t  in  8  signed T sample.
- in_dt  in  8  signed external dT; used only when dt_mode=0.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream (fuzzy core) accepts the pair.
- out_t  out  8  signed T; equals the accepted in_t.
- out_dt  out  8  signed dT.
- primed  out  1  history holds valid samples.

## Operation
- Accept condition: in_valid && in_ready. The output-valid and history updates below happen only on accept.
- History: circular buffer hist[0..N-1] of 8-bit signed samples, plus a write pointer wp of AVG_LOG2 bits that wraps modulo N. hist[wp] is always the sample accepted N accepts ago.
- FSM has two states, EMPTY and RUN; `primed` = (state == RUN).
- In EMPTY, on accept:
  - write in_t into all N entries;
  - leave wp unchanged;
  - set internal dT to 0;
  - go to RUN.
- In RUN, on accept:
  - compute diff = in_t - hist[wp] as a 9-bit signed value;
  - compute d = diff >>> AVG_LOG2 (arithmetic shift, floor rounding);
  - saturate d to [-128, 127];
  - write hist[wp] = in_t;
  - wp = wp + 1 (wraps).
- Output select: out_dt = (dt_mode ? internal dT : in_dt); out_t = in_t. The history updates in both modes.
- init:
  - forces state to EMPTY on the next edge;
  - has priority over the RUN path when it coincides with an accept: that sample is treated as the seed (EMPTY path), so out_dt = 0 when dt_mode=1;
  - does not cancel a pending output; the pending pair is still delivered unchanged.
- Saturation is reachable only when AVG_LOG2 = 0. For AVG_LOG2 ≥ 1 the result always fits in 8 bits.

## Timing
- Reset values:
  - out_valid = 0, out_t = 0, out_dt = 0;
  - primed = 0, state = EMPTY, wp = 0, all hist entries = 0;
  - in_ready = 1 (follows from out_valid = 0).
- Latency: the pair appears on out_* with out_valid = 1 one cycle after the accept edge.
- Output register:
  - out_valid sets on accept;
  - out_valid clears on out_ready when there is no simultaneous accept;
  - if the output is consumed and a new sample is accepted in the same cycle, out_valid stays 1 and out_* load the new pair.
- Throughput: one pair per cycle while out_ready = 1.
- Hold: out_t and out_dt stay stable while out_valid && !out_ready.
- Reset asserted mid-transfer: all state returns to reset values asynchronously, and the pending pair is dropped.
- dt_mode changing while a pair is pending does not alter that pair.

## Test plan
- Reset: assert rst_n = 0 for 4 cycles, then release -> out_valid = 0, out_t = 0, out_dt = 0, primed = 0, in_ready = 1.
- Pass-through: dt_mode = 0, sample (T = 100, dT = -100), out_ready = 1 -> next cycle out_t = 100, out_dt = -100, primed = 1.
- INIT, no spike: init pulse, then 5 samples of T = 0 with dt_mode = 1 -> five outputs, each with out_dt = 0. Repeat with a prior history of T = 120 -> still out_dt = 0 on every output.
- Ramp with N = 4:
  - stimulus: seed T = 0, then T = 4, 8, 12, 16, 20, 24;
  - required out_dt: 0, 1, 2, 3, 4, 4, 4;
  - check wp wrap after 4 accepts;
  - check floor rounding: seed T = 0, then T = -1 -> out_dt = -1.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and out_* stay stable. Raise out_ready -> the consume and the next accept happen in the same cycle, with no sample lost or duplicated.
- Saturation with AVG_LOG2 = 0: seed T = -128, then T = 127 -> out_dt = 127. Reseed at T = 127, then T = -128 -> out_dt = -128. Also assert init on the same cycle as an accept -> that output has out_dt = 0.
